// File: rtl/uart_rx_if.sv
// Serial-receive bundle between uart_rx (slave) and its line driver / byte consumer (master).
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling from a baud counter, glitch-checked start bit and framing error flag.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point, decided one cycle later.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        rx_s;
    logic        sample;

    assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    // The start check moves one cycle late; DATA/STOP keep their compare value
    // because that one-cycle offset is inherited from the later DATA entry.
    localparam logic [15:0] START_AT = 16'(HALF_DIV);

    logic rx_d1_q, rx_d2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_d1_q <= 1'b1;
            rx_d2_q <= 1'b1;
        end else begin
            rx_d1_q <= rx_s;
            rx_d2_q <= rx_d1_q;
        end
    end

    assign sample = (rx_s & rx_d1_q) | (rx_s & rx_d2_q) | (rx_d1_q & rx_d2_q);
`else
    localparam logic [15:0] START_AT = 16'(HALF_DIV - 1);

    assign sample = rx_s;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == START_AT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    shreg_d   = {sample, shreg_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sample) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must return high before a new start can be seen.
                if (rx_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= bus.rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = err_q;
    assign bus.rx_busy      = busy_q;

endmodule
